// File: rtl/mem_port_arbiter.sv
// Unified-memory port arbiter: serialises IF fetches and MEM-stage loads/stores
// over one req/ack port and raises the global pipeline stall while either waits.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    input  logic              branch_flush_i,
    output logic              port_req_o,
    output logic              port_we_o,
    output logic [ADDR_W-1:0] port_addr_o,
    output logic [DATA_W-1:0] port_wdata_o,
    input  logic [DATA_W-1:0] port_rdata_i,
    input  logic              port_ack_i,
    output logic              pipe_stall_o,
    output logic              timeout_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_IF,
        SERVE_MEM
    } state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;
    logic               if_done_q, if_done_d;
    logic               mem_done_q, mem_done_d;
    logic               discard_q, discard_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic mem_op;
    logic stall;
    logic timed_out;

    assign mem_op    = mem_rd_i | mem_wr_i;
    assign stall     = (mem_op & ~mem_done_q) | (if_req_i & ~if_done_q);
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        discard_d   = discard_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        // Pipeline advances on a stall-free edge: completed results are consumed.
        if (!stall) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
        end
        if (branch_flush_i) begin
            if_done_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (mem_op && !mem_done_q) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    we_d    = mem_wr_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = SERVE_MEM;
                end else if (if_req_i && !if_done_q) begin
                    addr_d  = if_addr_i;
                    we_d    = 1'b0;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = SERVE_IF;
                end
            end
            SERVE_MEM: begin
                if (port_ack_i || timed_out) begin
                    req_d      = 1'b0;
                    state_d    = IDLE;
                    mem_done_d = 1'b1;
                    if (!port_ack_i) begin
                        err_d       = 1'b1;
                        mem_rdata_d = '0;
                    end else if (!we_q) begin
                        mem_rdata_d = port_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SERVE_IF: begin
                if (port_ack_i || timed_out) begin
                    req_d     = 1'b0;
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    if (!port_ack_i) begin
                        err_d = 1'b1;
                    end
                    // A flush on the completing edge kills the fetch as well.
                    if (!(discard_q || branch_flush_i)) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = port_ack_i ? port_rdata_i : '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (branch_flush_i) begin
                        discard_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            discard_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            discard_q   <= discard_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign port_req_o    = req_q;
    assign port_we_o     = we_q;
    assign port_addr_o   = addr_q;
    assign port_wdata_o  = wdata_q;
    assign if_rdata_o    = if_rdata_q;
    assign mem_rdata_o   = mem_rdata_q;
    assign if_ready_o    = if_done_q;
    assign mem_ready_o   = mem_done_q;
    assign pipe_stall_o  = stall;
    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing cases, then randomized steps
// scored against a word-memory reference model through per-requester queues.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        flush = 1'b0;
    logic        port_req;
    logic        port_we;
    logic [31:0] port_addr;
    logic [31:0] port_wdata;
    logic [31:0] port_rdata = '0;
    logic        port_ack = 1'b0;
    logic        stall;
    logic        err;

    int n_tests = 0;
    int n_fail = 0;
    bit auto_ack = 1'b0;
    bit mon_en = 1'b0;

    logic [31:0] port_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] q_mem [$];
    logic [31:0] q_if [$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
        .branch_flush_i(flush),
        .port_req_o(port_req), .port_we_o(port_we),
        .port_addr_o(port_addr), .port_wdata_o(port_wdata),
        .port_rdata_i(port_rdata), .port_ack_i(port_ack),
        .pipe_stall_o(stall), .timeout_err_o(err)
    );

    function automatic logic [31:0] init_val(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Memory device: random 0..3 cycle ack latency once a request is seen.
    initial begin
        bit armed;
        int wcnt;
        armed = 1'b0;
        wcnt = 0;
        forever begin
            cyc();
            if (auto_ack) begin
                port_ack = 1'b0;
                port_rdata = $urandom;
                if (port_req) begin
                    if (!armed) begin
                        armed = 1'b1;
                        wcnt = $urandom_range(0, 3);
                    end
                    if (wcnt == 0) begin
                        port_ack = 1'b1;
                        if (port_we) begin
                            port_mem[port_addr] = port_wdata;
                        end else begin
                            port_rdata = port_mem.exists(port_addr) ?
                                port_mem[port_addr] : init_val(port_addr);
                        end
                    end else begin
                        wcnt--;
                    end
                end else begin
                    armed = 1'b0;
                end
            end
        end
    end

    // Monitor: each rising ready flag consumes one expected result.
    initial begin
        logic mem_prev;
        logic if_prev;
        mem_prev = 1'b0;
        if_prev = 1'b0;
        forever begin
            smp();
            if (mon_en) begin
                if (mem_ready && !mem_prev) begin
                    if (q_mem.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL mem_unexpected: got %h expected none", mem_rdata);
                    end else begin
                        chk("rnd_mem_rdata", mem_rdata, q_mem.pop_front());
                    end
                end
                if (if_ready && !if_prev) begin
                    if (q_if.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL if_unexpected: got %h expected none", if_rdata);
                    end else begin
                        chk("rnd_if_rdata", if_rdata, q_if.pop_front());
                    end
                end
            end
            mem_prev = mem_ready;
            if_prev = if_ready;
        end
    end

    initial begin
        logic [31:0] last_ld;
        logic [31:0] a;
        logic [31:0] v;
        int op;
        int k;

        repeat (2) cyc();
        rst = 1'b0;
        smp();
        chk("rst_port_req", 32'(port_req), 0);
        chk("rst_port_we", 32'(port_we), 0);
        chk("rst_port_addr", port_addr, 0);
        chk("rst_port_wdata", port_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_if_ready", 32'(if_ready), 0);
        chk("rst_mem_ready", 32'(mem_ready), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_stall", 32'(stall), 0);

        // Load with ack three cycles after the request rises
        cyc();
        mem_rd = 1'b1;
        mem_addr = 32'h40;
        smp();
        chk("ld_c0_stall", 32'(stall), 1);
        chk("ld_c0_req", 32'(port_req), 0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 4) begin
                port_ack = 1'b1;
                port_rdata = 32'hDEADBEEF;
            end
            smp();
            chk("ld_req_high", 32'(port_req), 1);
            chk("ld_stall_high", 32'(stall), 1);
            if (c == 1) begin
                chk("ld_addr", port_addr, 32'h40);
                chk("ld_we", 32'(port_we), 0);
            end
        end
        cyc();
        port_ack = 1'b0;
        port_rdata = '0;
        smp();
        chk("ld_ready", 32'(mem_ready), 1);
        chk("ld_rdata", mem_rdata, 32'hDEADBEEF);
        chk("ld_stall_rel", 32'(stall), 0);
        chk("ld_req_low", 32'(port_req), 0);
        cyc();
        mem_rd = 1'b0;
        smp();
        chk("ld_done_clr", 32'(mem_ready), 0);

        // Store (rd and wr both high) and fetch together: MEM first
        cyc();
        mem_rd = 1'b1;
        mem_wr = 1'b1;
        mem_addr = 32'h44;
        mem_wdata = 32'h12345678;
        if_req = 1'b1;
        if_addr = 32'h100;
        smp();
        chk("st_c0_stall", 32'(stall), 1);
        cyc();
        port_ack = 1'b1;
        port_rdata = 32'h0BADF00D;
        smp();
        chk("st_req", 32'(port_req), 1);
        chk("st_we", 32'(port_we), 1);
        chk("st_wdata", port_wdata, 32'h12345678);
        chk("st_addr", port_addr, 32'h44);
        cyc();
        port_ack = 1'b0;
        smp();
        chk("st_ready", 32'(mem_ready), 1);
        chk("st_rdata_kept", mem_rdata, 32'hDEADBEEF);
        chk("st_gap_req", 32'(port_req), 0);
        chk("st_stall_if", 32'(stall), 1);
        cyc();
        port_ack = 1'b1;
        port_rdata = 32'hCAFE0001;
        smp();
        chk("if_req", 32'(port_req), 1);
        chk("if_we", 32'(port_we), 0);
        chk("if_addr", port_addr, 32'h100);
        cyc();
        port_ack = 1'b0;
        smp();
        chk("if_ready", 32'(if_ready), 1);
        chk("if_rdata", if_rdata, 32'hCAFE0001);
        chk("both_mem_ready", 32'(mem_ready), 1);
        chk("both_stall_rel", 32'(stall), 0);
        cyc();
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        smp();
        chk("no_reserve", 32'(port_req), 0);
        chk("if_ready_clr", 32'(if_ready), 0);

        // Flush before ack discards the fetch; held request re-issues
        cyc();
        if_addr = 32'h200;
        cyc();
        smp();
        chk("fl_req", 32'(port_req), 1);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        port_ack = 1'b1;
        port_rdata = 32'hBAD00BAD;
        cyc();
        port_ack = 1'b0;
        smp();
        chk("fl_req_low", 32'(port_req), 0);
        chk("fl_not_ready", 32'(if_ready), 0);
        chk("fl_rdata_kept", if_rdata, 32'hCAFE0001);
        chk("fl_stall", 32'(stall), 1);
        cyc();
        port_ack = 1'b1;
        port_rdata = 32'h600D0001;
        smp();
        chk("fl_reissue", 32'(port_req), 1);
        chk("fl_reissue_addr", port_addr, 32'h200);
        cyc();
        port_ack = 1'b0;
        smp();
        chk("fl_ready", 32'(if_ready), 1);
        chk("fl_rdata_new", if_rdata, 32'h600D0001);

        // Flush on the same edge as the ack
        cyc();
        if_addr = 32'h204;
        cyc();
        port_ack = 1'b1;
        port_rdata = 32'hBAD00002;
        flush = 1'b1;
        smp();
        chk("fa_req", 32'(port_req), 1);
        cyc();
        port_ack = 1'b0;
        flush = 1'b0;
        smp();
        chk("fa_not_ready", 32'(if_ready), 0);
        chk("fa_rdata_kept", if_rdata, 32'h600D0001);
        cyc();
        port_ack = 1'b1;
        port_rdata = 32'h600D0002;
        smp();
        chk("fa_reissue", 32'(port_req), 1);
        cyc();
        port_ack = 1'b0;
        smp();
        chk("fa_ready", 32'(if_ready), 1);
        chk("fa_rdata", if_rdata, 32'h600D0002);
        cyc();
        if_req = 1'b0;

        // No ack: abort after 15 serve cycles
        cyc();
        mem_rd = 1'b1;
        mem_addr = 32'h48;
        for (int c = 1; c <= 15; c++) begin
            cyc();
            smp();
            chk("to_req_hold", 32'(port_req), 1);
        end
        cyc();
        smp();
        chk("to_req_drop", 32'(port_req), 0);
        chk("to_err", 32'(err), 1);
        chk("to_ready", 32'(mem_ready), 1);
        chk("to_rdata_zero", mem_rdata, 0);
        chk("to_stall_rel", 32'(stall), 0);
        cyc();
        mem_rd = 1'b0;
        repeat (3) cyc();
        smp();
        chk("to_err_sticky", 32'(err), 1);

        // Reset in the middle of a MEM access; late ack ignored
        cyc();
        mem_rd = 1'b1;
        mem_addr = 32'h4C;
        cyc();
        smp();
        chk("rs_req", 32'(port_req), 1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mem_rd = 1'b0;
        port_ack = 1'b1;
        port_rdata = 32'h77777777;
        smp();
        chk("rs_req_low", 32'(port_req), 0);
        chk("rs_err_clr", 32'(err), 0);
        chk("rs_addr", port_addr, 0);
        chk("rs_if_rdata", if_rdata, 0);
        chk("rs_mem_rdata", mem_rdata, 0);
        cyc();
        port_ack = 1'b0;
        smp();
        chk("rs_late_ready", 32'(mem_ready), 0);
        chk("rs_late_rdata", mem_rdata, 0);
        chk("rs_late_req", 32'(port_req), 0);

        // Randomized pipeline steps against the reference memory
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        last_ld = '0;
        auto_ack = 1'b1;
        mon_en = 1'b1;
        for (int s = 0; s < 250; s++) begin
            cyc();
            op = $urandom_range(0, 3);
            a = 32'($urandom_range(0, 7)) * 4;
            mem_addr = a;
            mem_wdata = $urandom;
            mem_rd = (op == 1) || (op == 3);
            mem_wr = (op == 2) || (op == 3);
            if (op >= 2) begin
                ref_mem[a] = mem_wdata;
                q_mem.push_back(last_ld);
            end else if (op == 1) begin
                v = ref_rd(a);
                last_ld = v;
                q_mem.push_back(v);
            end
            if_req = ($urandom_range(0, 3) != 0);
            if_addr = 32'($urandom_range(0, 7)) * 4;
            if (if_req) begin
                q_if.push_back(ref_rd(if_addr));
            end
            for (k = 0; k < 100; k++) begin
                smp();
                if (!stall) break;
            end
            n_tests++;
            if (k == 100) begin
                n_fail++;
                $display("FAIL step_bound: step %0d still stalled after %0d cycles", s, k);
            end
        end
        cyc();
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        if_req = 1'b0;
        repeat (5) cyc();
        smp();
        chk("q_mem_drained", 32'(q_mem.size()), 0);
        chk("q_if_drained", 32'(q_if.size()), 0);
        chk("rnd_no_err", 32'(err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
